// File: rtl/manual_param_scheduler.sv
// Shares INC/DEC/SEL push-buttons among N_PARAM saturating parameters, with debounce and hold-to-repeat.
// Latency: a value or o_sel changes on the edge after the debounced press event; there is no backpressure, and presses during HOLD/REPEAT are dropped.
module manual_param_scheduler #(
    parameter int N_PARAM      = 4,
    parameter int N_BIT        = 8,
    parameter int STEP         = 1,
    parameter int VAL_MIN      = 0,
    parameter int VAL_MAX      = 255,
    parameter int VAL_RST      = 0,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int HOLD_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000,
    localparam int SEL_W       = $clog2(N_PARAM)
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_inc_btn,
    input  logic                     i_dec_btn,
    input  logic                     i_sel_btn,
    output logic [SEL_W-1:0]         o_sel,
    output logic [N_PARAM*N_BIT-1:0] o_values,
    output logic [N_BIT-1:0]         o_cur_value,
    output logic                     o_update
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [N_BIT:0] STEP_X = (N_BIT+1)'(STEP);
    localparam logic [N_BIT:0] MIN_X  = (N_BIT+1)'(VAL_MIN);
    localparam logic [N_BIT:0] MAX_X  = (N_BIT+1)'(VAL_MAX);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    // Button bit order: 0 = inc, 1 = dec, 2 = sel
    logic [2:0]      btn_raw, btn_s1, btn_s2, btn_lvl, btn_prs;
    logic [DB_W-1:0] db_cnt [3];

    assign btn_raw = {i_sel_btn, i_dec_btn, i_inc_btn};

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            btn_s1  <= '1;
            btn_s2  <= '1;
            btn_lvl <= '1;
            btn_prs <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            for (int i = 0; i < 3; i++) begin
                btn_prs[i] <= 1'b0;
                if (btn_s2[i] != btn_lvl[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                        btn_lvl[i] <= btn_s2[i];
                        btn_prs[i] <= btn_lvl[i];
                        db_cnt[i]  <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    state_t           state, state_n;
    logic             dir_up, dir_up_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             held, hold_done, rep_done;
    logic             step_up, step_dn, sel_adv;

    assign held      = dir_up ? ~btn_lvl[0] : ~btn_lvl[1];
    assign hold_done = (cnt == CNT_W'(HOLD_CYC - 1));
    assign rep_done  = (cnt == CNT_W'(REPEAT_CYC - 1));

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state  <= IDLE;
            dir_up <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            dir_up <= dir_up_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        dir_up_n = dir_up;
        case (state)
            IDLE: begin
                if (!btn_prs[2] && (btn_prs[0] != btn_prs[1])) begin
                    state_n  = HOLD;
                    dir_up_n = btn_prs[0];
                end
            end
            HOLD:    if (!held) state_n = IDLE; else if (hold_done) state_n = REPEAT;
            REPEAT:  if (!held) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        sel_adv = 1'b0;
        cnt_n   = '0;
        case (state)
            IDLE: begin
                sel_adv = btn_prs[2];
                step_up = !btn_prs[2] && btn_prs[0] && !btn_prs[1];
                step_dn = !btn_prs[2] && btn_prs[1] && !btn_prs[0];
            end
            HOLD, REPEAT: begin
                if (held) begin
                    if ((state == HOLD) ? hold_done : rep_done) begin
                        step_up = dir_up;
                        step_dn = !dir_up;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    logic [N_BIT-1:0] val [N_PARAM];
    logic [N_BIT:0]   cur_x, up_x, dn_x;
    logic [N_BIT-1:0] new_val;

    // Saturation is evaluated one bit wider so neither bound can wrap
    always_comb begin
        cur_x   = {1'b0, val[o_sel]};
        up_x    = cur_x + STEP_X;
        dn_x    = cur_x - STEP_X;
        new_val = val[o_sel];
        if (step_up) new_val = (up_x > MAX_X) ? MAX_X[N_BIT-1:0] : up_x[N_BIT-1:0];
        if (step_dn) new_val = (cur_x < MIN_X + STEP_X) ? MIN_X[N_BIT-1:0] : dn_x[N_BIT-1:0];
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            for (int k = 0; k < N_PARAM; k++) val[k] <= N_BIT'(VAL_RST);
            o_sel    <= '0;
            o_update <= 1'b0;
        end else begin
            o_update <= 1'b0;
            if ((step_up || step_dn) && (new_val != val[o_sel])) begin
                val[o_sel] <= new_val;
                o_update   <= 1'b1;
            end
            if (sel_adv)
                o_sel <= (o_sel == SEL_W'(N_PARAM - 1)) ? '0 : o_sel + 1'b1;
        end
    end

    always_comb begin
        o_values = '0;
        for (int k = 0; k < N_PARAM; k++) o_values[k*N_BIT +: N_BIT] = val[k];
    end

    assign o_cur_value = val[o_sel];

endmodule

// File: tb/tb_manual_param_scheduler.sv
// Directed bench for manual_param_scheduler with short debounce/hold/repeat timings.
module tb_manual_param_scheduler;
    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b0;
    logic        i_inc_btn = 1'b1;
    logic        i_dec_btn = 1'b1;
    logic        i_sel_btn = 1'b1;
    logic [1:0]  o_sel;
    logic [23:0] o_values;
    logic [7:0]  o_cur_value;
    logic        o_update;

    int checks = 0;
    int errors = 0;
    int upd_total = 0;
    int u0;

    manual_param_scheduler #(
        .N_PARAM(3), .N_BIT(8), .STEP(3), .VAL_MIN(2), .VAL_MAX(10), .VAL_RST(5),
        .DEBOUNCE_CYC(4), .HOLD_CYC(20), .REPEAT_CYC(5)
    ) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_inc_btn(i_inc_btn), .i_dec_btn(i_dec_btn),
        .i_sel_btn(i_sel_btn), .o_sel(o_sel), .o_values(o_values),
        .o_cur_value(o_cur_value), .o_update(o_update)
    );

    always #5 i_CLK = ~i_CLK;

    always @(negedge i_CLK) if (o_update === 1'b1) upd_total++;

    task automatic tick(input int n);
        repeat (n) @(posedge i_CLK);
        #1;
    endtask

    task automatic do_reset();
        i_RST = 1'b0;
        tick(1);
        i_RST = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        i_RST = 1'b0;
        tick(3);
        checks++;
        if (o_values !== 24'h050505) begin errors++; $display("FAIL reset_values got %h exp 050505", o_values); end
        checks++;
        if (o_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", o_sel); end
        checks++;
        if (o_update !== 1'b0) begin errors++; $display("FAIL reset_update got %b exp 0", o_update); end
        checks++;
        if (o_cur_value !== 8'd5) begin errors++; $display("FAIL reset_cur got %0d exp 5", o_cur_value); end
        i_RST = 1'b1;
        tick(2);
    endtask

    task automatic test_single_step();
        u0 = upd_total;
        i_inc_btn = 1'b0;
        tick(10);
        i_inc_btn = 1'b1;
        tick(12);
        checks++;
        if (o_values[7:0] !== 8'd8) begin errors++; $display("FAIL single_step_p0 got %0d exp 8", o_values[7:0]); end
        checks++;
        if (upd_total - u0 !== 1) begin errors++; $display("FAIL single_step_updates got %0d exp 1", upd_total - u0); end
        checks++;
        if (o_cur_value !== 8'd8) begin errors++; $display("FAIL single_step_cur got %0d exp 8", o_cur_value); end
    endtask

    task automatic test_glitch();
        u0 = upd_total;
        i_inc_btn = 1'b0;
        tick(2);
        i_inc_btn = 1'b1;
        tick(12);
        checks++;
        if (o_values[7:0] !== 8'd8) begin errors++; $display("FAIL glitch_p0 got %0d exp 8", o_values[7:0]); end
        checks++;
        if (upd_total - u0 !== 0) begin errors++; $display("FAIL glitch_updates got %0d exp 0", upd_total - u0); end
    endtask

    task automatic test_hold_saturate();
        do_reset();
        u0 = upd_total;
        i_inc_btn = 1'b0;
        tick(12);
        checks++;
        if (o_values[7:0] !== 8'd8) begin errors++; $display("FAIL hold_first_step got %0d exp 8", o_values[7:0]); end
        tick(28);
        checks++;
        if (o_values[7:0] !== 8'd10) begin errors++; $display("FAIL hold_saturate got %0d exp 10", o_values[7:0]); end
        tick(20);
        i_inc_btn = 1'b1;
        tick(15);
        checks++;
        if (o_values[7:0] !== 8'd10) begin errors++; $display("FAIL hold_after_release got %0d exp 10", o_values[7:0]); end
        checks++;
        if (upd_total - u0 !== 2) begin errors++; $display("FAIL hold_updates got %0d exp 2", upd_total - u0); end
        // back in IDLE: a fresh dec press must step immediately
        i_dec_btn = 1'b0;
        tick(10);
        i_dec_btn = 1'b1;
        tick(12);
        checks++;
        if (o_values[7:0] !== 8'd7) begin errors++; $display("FAIL hold_idle_dec got %0d exp 7", o_values[7:0]); end
    endtask

    task automatic press_sel();
        i_sel_btn = 1'b0;
        tick(8);
        i_sel_btn = 1'b1;
        tick(10);
    endtask

    task automatic press_dec();
        i_dec_btn = 1'b0;
        tick(8);
        i_dec_btn = 1'b1;
        tick(10);
    endtask

    task automatic test_select_dec();
        do_reset();
        press_sel();
        checks++;
        if (o_sel !== 2'd1) begin errors++; $display("FAIL sel_first got %0d exp 1", o_sel); end
        u0 = upd_total;
        press_dec();
        checks++;
        if (o_values[15:8] !== 8'd2) begin errors++; $display("FAIL dec_p1 got %0d exp 2", o_values[15:8]); end
        checks++;
        if (o_cur_value !== 8'd2) begin errors++; $display("FAIL dec_cur got %0d exp 2", o_cur_value); end
        checks++;
        if (upd_total - u0 !== 1) begin errors++; $display("FAIL dec_updates got %0d exp 1", upd_total - u0); end
        press_dec();
        checks++;
        if (o_values[15:8] !== 8'd2) begin errors++; $display("FAIL dec_sat_p1 got %0d exp 2", o_values[15:8]); end
        checks++;
        if (upd_total - u0 !== 1) begin errors++; $display("FAIL dec_sat_updates got %0d exp 1", upd_total - u0); end
        press_sel();
        checks++;
        if (o_sel !== 2'd2) begin errors++; $display("FAIL sel_second got %0d exp 2", o_sel); end
        press_sel();
        checks++;
        if (o_sel !== 2'd0) begin errors++; $display("FAIL sel_wrap got %0d exp 0", o_sel); end
        checks++;
        if (o_values !== 24'h050205) begin errors++; $display("FAIL sel_others got %h exp 050205", o_values); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        u0 = upd_total;
        i_inc_btn = 1'b0;
        i_dec_btn = 1'b0;
        tick(10);
        i_inc_btn = 1'b1;
        i_dec_btn = 1'b1;
        tick(12);
        checks++;
        if (o_values !== 24'h050505) begin errors++; $display("FAIL both_values got %h exp 050505", o_values); end
        checks++;
        if (upd_total - u0 !== 0) begin errors++; $display("FAIL both_updates got %0d exp 0", upd_total - u0); end
        i_inc_btn = 1'b0;
        tick(40);
        i_dec_btn = 1'b0;
        tick(10);
        i_dec_btn = 1'b1;
        tick(12);
        checks++;
        if (o_values !== 24'h05050A) begin errors++; $display("FAIL repeat_dec_values got %h exp 05050a", o_values); end
        checks++;
        if (upd_total - u0 !== 2) begin errors++; $display("FAIL repeat_dec_updates got %0d exp 2", upd_total - u0); end
        i_inc_btn = 1'b1;
        tick(12);
    endtask

    task automatic test_reset_in_repeat();
        do_reset();
        i_inc_btn = 1'b0;
        tick(45);
        checks++;
        if (o_values[7:0] !== 8'd10) begin errors++; $display("FAIL rr_before got %0d exp 10", o_values[7:0]); end
        i_RST = 1'b0;
        tick(1);
        i_RST = 1'b1;
        checks++;
        if (o_values !== 24'h050505) begin errors++; $display("FAIL rr_values got %h exp 050505", o_values); end
        checks++;
        if (o_sel !== 2'd0) begin errors++; $display("FAIL rr_sel got %0d exp 0", o_sel); end
        tick(4);
        checks++;
        if (o_values[7:0] !== 8'd5) begin errors++; $display("FAIL rr_no_early_step got %0d exp 5", o_values[7:0]); end
        tick(8);
        checks++;
        if (o_values[7:0] !== 8'd8) begin errors++; $display("FAIL rr_fresh_press got %0d exp 8", o_values[7:0]); end
        i_inc_btn = 1'b1;
        tick(12);
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_glitch();
        test_hold_saturate();
        test_select_dec();
        test_simultaneous();
        test_reset_in_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
